// File: rtl/team_06_echo_pkg.sv
// -----------------------------------------------------------------------------
// team_06_echo_pkg
// Shared definitions for the echo-effect history server.
//   DEF_ADDR_W        : default buffer address width (8192-sample buffer)
//   DEF_DATA_W        : default audio sample width
//   echo_hist_state_t : request sequencer states
//   sample_t          : one audio sample at the default width
// -----------------------------------------------------------------------------
package team_06_echo_pkg;

   localparam int DEF_ADDR_W = 13;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } echo_hist_state_t;

   typedef logic [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/team_06_echo_ptr_unit.sv
// -----------------------------------------------------------------------------
// team_06_echo_ptr_unit
// Write pointer, fill level and history read-address generation for the
// circular delay buffer.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   advance      in   one write has been accepted by memory
//   offset_q     in   age of the requested sample (0 = most recent save)
//   wr_ptr       out  address the next save goes to
//   rd_addr      out  address of the sample saved offset_q+1 saves ago
//   offset_miss  out  requested age is older than anything stored so far
// DEPTH must equal 2**ADDR_W so that pointer arithmetic wraps naturally.
// -----------------------------------------------------------------------------
module team_06_echo_ptr_unit
   import team_06_echo_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic [ADDR_W-1:0] offset_q,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              offset_miss
);

   // One extra bit so the fill level can represent a completely full buffer.
   localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0] fill_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         fill_reg <= '0;
      end else if (advance) begin
         // Power-of-two depth: the ADDR_W-bit increment wraps DEPTH-1 -> 0.
         wr_ptr <= wr_ptr + ADDR_W'(1);
         if (fill_reg != FILL_MAX) begin
            fill_reg <= fill_reg + (ADDR_W+1)'(1);
         end
      end
   end

   // wr_ptr points at the next free slot, so the newest sample lives at
   // wr_ptr-1; the subtraction wraps modulo DEPTH.
   assign rd_addr     = wr_ptr - ADDR_W'(1) - offset_q;
   assign offset_miss = ({1'b0, offset_q} >= fill_reg);

endmodule

// File: rtl/team_06_echo_history_server.sv
// -----------------------------------------------------------------------------
// team_06_echo_history_server
// Responder side of the echo-effect history interface. Every processed sample
// is saved into a circular delay buffer held in external sample memory, and
// search requests return the sample saved offset+1 saves ago.
// Ports:
//   clk, rst                 clock / synchronous active-low reset
//   sample_valid, save_audio new sample to store
//   search, offset           history read request (ignored while busy)
//   past_output              returned history sample (held until next response)
//   search_enable            one-cycle strobe: past_output valid
//   busy                     a search is pending or in flight
//   overrun                  sticky: a pending save was overwritten
//   mem_req/we/addr/wdata    shared SRAM port, held stable until mem_ack
//   mem_ack, mem_rdata       SRAM accept / read data (same cycle as ack)
//   err                      sticky memory watchdog error
// Optional feature macro: TEAM_06_ECHO_TIMEOUT_EN
//   defined   : a watchdog aborts a memory access after TIMEOUT_CYC cycles
//               without mem_ack and sets err
//   undefined : accesses wait indefinitely and err is tied 0
// -----------------------------------------------------------------------------
module team_06_echo_history_server
   import team_06_echo_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 2**ADDR_W
`ifdef TEAM_06_ECHO_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] save_audio,
   input  logic              search,
   input  logic [ADDR_W-1:0] offset,
   output logic [DATA_W-1:0] past_output,
   output logic              search_enable,
   output logic              busy,
   output logic              overrun,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   echo_hist_state_t  state_reg;
   logic              wr_pend_reg;
   logic              rd_pend_reg;
   logic [DATA_W-1:0] wr_buf_reg;
   logic [ADDR_W-1:0] offset_q_reg;
   logic [DATA_W-1:0] rd_data_reg;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_addr;
   logic              offset_miss;
   logic              wr_ack;

   assign wr_ack = (state_reg == WRITE) && mem_ack;
   assign busy   = rd_pend_reg || (state_reg == READ) || (state_reg == RESP);

   team_06_echo_ptr_unit #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ptr (
      .clk         (clk),
      .rst         (rst),
      .advance     (wr_ack),
      .offset_q    (offset_q_reg),
      .wr_ptr      (wr_ptr),
      .rd_addr     (rd_addr),
      .offset_miss (offset_miss)
   );

`ifdef TEAM_06_ECHO_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             tmo_hit;
   // Counter is 0 on the first cycle of an access, so this fires on the
   // TIMEOUT_CYC-th cycle without an ack.
   assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         wr_pend_reg   <= 1'b0;
         rd_pend_reg   <= 1'b0;
         wr_buf_reg    <= '0;
         offset_q_reg  <= '0;
         rd_data_reg   <= '0;
         past_output   <= '0;
         search_enable <= 1'b0;
         overrun       <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
`ifdef TEAM_06_ECHO_TIMEOUT_EN
         tmo_cnt_reg   <= '0;
         err           <= 1'b0;
`endif
      end else begin
         search_enable <= 1'b0;

         // Single-entry write buffer. A save landing on the ack cycle of the
         // previous one simply queues; any other save while one is pending
         // replaces the buffered sample and flags overrun.
         if (sample_valid) begin
            wr_buf_reg  <= save_audio;
            wr_pend_reg <= 1'b1;
            if (wr_pend_reg && !wr_ack) begin
               overrun <= 1'b1;
            end
         end

         if (search && !busy) begin
            offset_q_reg <= offset;
            rd_pend_reg  <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
`ifdef TEAM_06_ECHO_TIMEOUT_EN
               tmo_cnt_reg <= '0;
`endif
               // Writes first so a search always sees every earlier save.
               if (wr_pend_reg) begin
                  state_reg <= WRITE;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= wr_ptr;
                  mem_wdata <= wr_buf_reg;
               end else if (rd_pend_reg && offset_miss) begin
                  // Nothing that old has been stored yet: answer 0 locally.
                  state_reg   <= RESP;
                  rd_data_reg <= '0;
                  rd_pend_reg <= 1'b0;
               end else if (rd_pend_reg) begin
                  state_reg <= READ;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= rd_addr;
               end
            end

            WRITE: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  state_reg <= IDLE;
                  if (!sample_valid) begin
                     wr_pend_reg <= 1'b0;
                  end
               end
`ifdef TEAM_06_ECHO_TIMEOUT_EN
               else if (tmo_hit) begin
                  // Drop the sample; pointer and fill stay where they were.
                  mem_req   <= 1'b0;
                  err       <= 1'b1;
                  state_reg <= IDLE;
                  if (!sample_valid) begin
                     wr_pend_reg <= 1'b0;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
               end
`endif
            end

            READ: begin
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  rd_data_reg <= mem_rdata;
                  rd_pend_reg <= 1'b0;
                  state_reg   <= RESP;
               end
`ifdef TEAM_06_ECHO_TIMEOUT_EN
               else if (tmo_hit) begin
                  mem_req     <= 1'b0;
                  err         <= 1'b1;
                  rd_data_reg <= '0;
                  rd_pend_reg <= 1'b0;
                  state_reg   <= RESP;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
               end
`endif
            end

            RESP: begin
               past_output   <= rd_data_reg;
               search_enable <= 1'b1;
               state_reg     <= IDLE;
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_team_06_echo_history_server.sv
`timescale 1ns/1ps
module tb_team_06_echo_history_server;
   import team_06_echo_pkg::*;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              sample_valid = 1'b0;
   logic [DATA_W-1:0] save_audio = '0;
   logic              search = 1'b0;
   logic [ADDR_W-1:0] offset = '0;
   logic [DATA_W-1:0] past_output;
   logic              search_enable;
   logic              busy;
   logic              overrun;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              err;

   always #5 clk = ~clk;

   team_06_echo_history_server dut (
      .clk           (clk),
      .rst           (rst),
      .sample_valid  (sample_valid),
      .save_audio    (save_audio),
      .search        (search),
      .offset        (offset),
      .past_output   (past_output),
      .search_enable (search_enable),
      .busy          (busy),
      .overrun       (overrun),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .err           (err)
   );

   // ---------------- sample memory model ----------------
   logic [DATA_W-1:0] mem [0:8191];
   int ack_wait = 0;
   int wait_cnt = 0;
   int acc_n = 0;
   int wr_n = 0;
   int se_n = 0;
   int last_wr_addr = -1;
   int last_rd_addr = -1;
   int last_wr_seq = 0;
   int last_rd_seq = 0;

   assign mem_ack   = mem_req && (wait_cnt >= ack_wait);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (mem_req && mem_ack) begin
         acc_n <= acc_n + 1;
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_n          <= wr_n + 1;
            last_wr_addr  <= int'(mem_addr);
            last_wr_seq   <= acc_n;
         end else begin
            last_rd_addr <= int'(mem_addr);
            last_rd_seq  <= acc_n;
         end
      end
      if (search_enable) se_n <= se_n + 1;
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic save(input sample_t v);
      sample_valid = 1'b1;
      save_audio   = v;
      tick();
      sample_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Search against an idle server with zero-wait memory: fixed latency.
   task automatic search_fixed(input logic [ADDR_W-1:0] off, input logic [ADDR_W-1:0] exp_addr,
                               input sample_t exp_data, input string tag);
      search = 1'b1;
      offset = off;
      tick();
      search = 1'b0;
      check({tag, "_se_k0"}, search_enable, 0);
      check({tag, "_busy_k0"}, busy, 1);
      tick();
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_addr"}, mem_addr, exp_addr);
      tick();
      check({tag, "_se_k2"}, search_enable, 0);
      tick();
      check({tag, "_se_k3"}, search_enable, 1);
      check({tag, "_data"}, past_output, exp_data);
      $display("search %s offset=%0d addr=%0d past_output=%02h", tag, off, mem_addr, past_output);
   endtask

   task automatic wait_resp(input int budget, input string tag);
      int n = 0;
      while (search_enable !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_resp_seen"}, search_enable, 1);
      $display("response %s past_output=%02h after %0d cycles", tag, past_output, n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_before;
      int se_before;
      int wr_before;

      // ---- reset held with sample_valid active ----
      rst          = 1'b0;
      sample_valid = 1'b1;
      save_audio   = 8'd55;
      repeat (3) tick();
      check("rst_past_output", past_output, 0);
      check("rst_search_enable", search_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_err", err, 0);
      rst          = 1'b1;
      sample_valid = 1'b0;
      tick();

      // ---- search on empty buffer: answered locally with 0 ----
      acc_before = acc_n;
      search = 1'b1;
      offset = '0;
      tick();
      search = 1'b0;
      wait_resp(10, "empty");
      check("empty_data", past_output, 0);
      check("empty_no_mem", acc_n, acc_before);

      // ---- basic echo ----
      save(8'd10);
      save(8'd20);
      save(8'd30);
      search_fixed(13'd1, 13'd1, 8'd20, "basic_off1");
      tick();
      check("basic_se_one_cycle", search_enable, 0);
      check("basic_hold", past_output, 8'd20);
      search_fixed(13'd2, 13'd0, 8'd10, "basic_off2");
      tick();
      // offset equal to fill: older than anything stored
      acc_before = acc_n;
      search = 1'b1;
      offset = 13'd3;
      tick();
      search = 1'b0;
      wait_resp(10, "miss_off3");
      check("miss_data", past_output, 0);
      check("miss_no_mem", acc_n, acc_before);
      tick();

      // ---- collision: save and search in the same cycle ----
      do_reset();
      for (int i = 1; i <= 5; i++) save(8'(i));
      sample_valid = 1'b1;
      save_audio   = 8'd77;
      search       = 1'b1;
      offset       = '0;
      tick();
      sample_valid = 1'b0;
      search       = 1'b0;
      wait_resp(20, "coll");
      check("coll_data", past_output, 8'd77);
      check("coll_wr_addr", last_wr_addr, 5);
      check("coll_rd_addr", last_rd_addr, 5);
      check("coll_order", last_rd_seq - last_wr_seq, 1);
      tick();

      // ---- overrun and busy with a slow memory ----
      ack_wait  = 10;
      se_before = se_n;
      wr_before = wr_n;
      search = 1'b1;
      offset = '0;
      tick();
      search = 1'b0;
      tick();
      sample_valid = 1'b1;
      save_audio   = 8'd88;
      tick();
      sample_valid = 1'b0;
      check("ovr_busy", busy, 1);
      check("ovr_no_overrun_yet", overrun, 0);
      search = 1'b1;
      offset = 13'd3;
      tick();
      search       = 1'b0;
      sample_valid = 1'b1;
      save_audio   = 8'd99;
      tick();
      sample_valid = 1'b0;
      check("ovr_overrun", overrun, 1);
      wait_resp(40, "ovr");
      check("ovr_data", past_output, 8'd77);
      repeat (30) tick();
      check("ovr_one_response", se_n - se_before, 1);
      check("ovr_one_write", wr_n - wr_before, 1);
      check("ovr_written_value", mem[6], 8'd99);
      check("ovr_written_addr", last_wr_addr, 6);
      check("ovr_idle_busy", busy, 0);
      ack_wait = 0;
      search_fixed(13'd0, 13'd6, 8'd99, "after_ovr");
      tick();

      // ---- reset in the middle of a read ----
      ack_wait = 10;
      search = 1'b1;
      offset = '0;
      tick();
      search = 1'b0;
      tick();
      check("midrst_req_before", mem_req, 1);
      rst = 1'b0;
      tick();
      check("midrst_req", mem_req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun", overrun, 0);
      rst      = 1'b1;
      ack_wait = 0;
      tick();

      // ---- wrap: 8194 saves, value = index[7:0] ----
      for (int i = 0; i < 8194; i++) save(8'(i));
      search_fixed(13'd2, 13'd8191, 8'hFF, "wrap_off2");
      tick();
      search_fixed(13'd8191, 13'd2, 8'h02, "full_off_max");
      tick();

`ifdef TEAM_06_ECHO_TIMEOUT_EN
      // ---- read never acknowledged ----
      check("tmo_err_before", err, 0);
      ack_wait = 1000000;
      search = 1'b1;
      offset = '0;
      tick();
      search = 1'b0;
      wait_resp(100, "tmo");
      check("tmo_err", err, 1);
      check("tmo_data", past_output, 0);
      check("tmo_req_dropped", mem_req, 0);
      ack_wait = 0;
`else
      check("err_tied_low", err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/team_06_echo_history_server.md
Name: team_06_echo_history_server

Overview:
- Responder side of the echo-effect history interface.
- Stores every processed output sample (save_audio) into a circular delay buffer in external sample memory.
- Services search requests carrying a sample offset by returning the sample written offset+1 saves ago on past_output, with a one-cycle search_enable strobe.
- Sits between the echo effect block and the shared SRAM port.

Parameters:
- ADDR_W, 13, buffer address width; must match offset width.
- DATA_W, 8, audio sample width.
- DEPTH, 8192, buffer length in samples; must equal 2**ADDR_W.
- TIMEOUT_CYC, 64, memory ack watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- sample_valid  in  1  one-cycle strobe: save_audio holds a new sample.
- save_audio  in  DATA_W  sample to store.
- search  in  1  one-cycle strobe: history read request.
- offset  in  ADDR_W  age of requested sample; 0 = most recent save.
- past_output  out  DATA_W  returned history sample.
- search_enable  out  1  one-cycle strobe: past_output valid.
- busy  out  1  high while a search is pending or in flight.
- overrun  out  1  sticky: a save was overwritten before it reached memory.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  request accepted or completed; rdata valid on same cycle for reads.
- mem_rdata  in  DATA_W  read data.
- err  out  1  sticky watchdog error; tied 0 without the optional feature.

Behaviour:

Reset (rst == 0 at a clk edge):
- All outputs 0.
- wr_ptr = 0, fill = 0, both pending flags clear, FSM = IDLE.
- Reset mid-transaction abandons the transaction; mem_req is 0 from the reset edge.

Write capture:
- On sample_valid, latch save_audio into wr_buf and set wr_pend.
- If wr_pend is already set and not being acked this cycle: wr_buf is overwritten and overrun is set.

Search capture:
- On search with busy == 0, latch offset and set rd_pend.
- Search while busy == 1 is ignored.
- busy = rd_pend | (state in READ or RESP).

FSM states: IDLE, WRITE, READ, RESP.

IDLE:
- wr_pend → WRITE. Writes take priority over reads.
- Else rd_pend and offset_q >= fill → RESP with data 0; no memory access.
- Else rd_pend → READ.

WRITE:
- mem_req = 1, mem_we = 1, mem_addr = wr_ptr, mem_wdata = wr_buf.
- On mem_ack: wr_ptr increments modulo DEPTH (8191 → 0), fill increments saturating at DEPTH, wr_pend clears, → IDLE.
- A sample_valid on the ack cycle sets wr_pend with the new data; no overrun.

READ:
- mem_req = 1, mem_we = 0, mem_addr = (wr_ptr − 1 − offset_q) mod DEPTH (ADDR_W-bit wraparound subtraction).
- On mem_ack: capture mem_rdata, clear rd_pend, → RESP.

RESP:
- past_output updated, search_enable = 1 for exactly one cycle, → IDLE.
- past_output holds its value until the next RESP.

Timing:
- Latency with idle FSM, no pending write and zero-wait ack: search sampled at edge k → search_enable high during cycle k+3.
- mem_req, mem_we, mem_addr and mem_wdata are stable from request assertion until ack.
- fill = DEPTH means the buffer is full; every offset then hits memory.

Optional Feature:
- Macro: TEAM_06_ECHO_TIMEOUT_EN.
- Enabled:
  - Counter runs while in WRITE or READ.
  - Reaching TIMEOUT_CYC cycles without mem_ack drops mem_req and sets err.
  - WRITE aborts: sample dropped, wr_ptr and fill unchanged.
  - READ → RESP with past_output = 0.
- Disabled: no counter; FSM waits indefinitely; err constant 0.

Decomposition:
- Package team_06_echo_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum echo_hist_state_t {IDLE, WRITE, READ, RESP}.
  - Shared sample typedef sample_t.
- Sub-module team_06_echo_ptr_unit holds wr_ptr, the fill counter and the read-address subtraction.
- The FSM and handshakes stay in the top module.

Test Plan:
- Reset:
  - Hold rst = 0 for 3 cycles with sample_valid = 1 → all outputs 0, no mem_req.
  - Release, then search offset = 0 → search_enable with past_output = 0, no memory access (fill = 0).
- Basic echo:
  - Save 10, 20, 30 with zero-wait ack, then search offset = 1 → mem_addr = 1, past_output = 20.
  - search_enable asserts 3 cycles after search.
- Wrap:
  - Save 8194 samples with value = index[7:0], then search offset = 2 → mem_addr = 8191, past_output = 0xFF.
- Collision:
  - Assert sample_valid (value 77) and search (offset 0) in the same cycle after 5 saves.
  - → WRITE completes first, then READ at address 5, past_output = 77.
- Overrun and busy:
  - Memory acks after 10 cycles; two sample_valid pulses 2 cycles apart → overrun = 1, only the second value is written.
  - A second search while busy → ignored, only one search_enable.
- Timeout (TEAM_06_ECHO_TIMEOUT_EN):
  - Never ack a read; after 64 cycles → err = 1, search_enable with past_output = 0, mem_req = 0.
